// File: rtl/stable_level_pkg.sv
// Shared types and elaboration helpers for the stable level detector.
//   state_t      : per-channel filter state (LOW, RISING, HIGH, FALLING)
//   us_to_cycles : converts a microsecond time to clk cycles, optional clamp to 1
//   ctr_width    : width of a saturating counter that can reach max(a, d)
package stable_level_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } state_t;

    localparam int unsigned HZ_PER_MHZ = 32'd1000000;

    // Whole cycles per microsecond times the requested time; min_one forces at least one cycle.
    function automatic int unsigned us_to_cycles(input int unsigned clk_rate,
                                                 input int unsigned us,
                                                 input bit          min_one);
        int unsigned cycles;
        cycles = (clk_rate / HZ_PER_MHZ) * us;
        if (min_one && (cycles == 32'd0)) begin
            cycles = 32'd1;
        end
        return cycles;
    endfunction

    // Counter width for the larger of the two hold times; never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned a,
                                              input int unsigned d);
        int unsigned m;
        int unsigned w;
        m = (a > d) ? a : d;
        w = $clog2(m + 32'd1);
        if (w == 32'd0) begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage : stable_level_pkg

// File: rtl/stable_level_detector_chan.sv
// One channel of the stable level detector.
// Synchronises an asynchronous level, applies polarity, and filters it through a
// hold-time FSM so that ready only asserts after A_CYCLES consecutive active
// samples and only drops after D_CYCLES consecutive inactive samples (0 = at once).
// Ports:
//   clk    : system clock
//   rst    : asynchronous reset, active low
//   clr    : synchronous clear back to LOW (sync flops keep running)
//   lvl_in : raw asynchronous level
//   ready  : registered filtered active flag
//   rise   : registered one-cycle pulse on ready 0->1
//   fall   : registered one-cycle pulse on ready 1->0
module stable_level_chan
    import stable_level_pkg::*;
#(
    parameter int unsigned A_CYCLES    = 32'd8,
    parameter int unsigned D_CYCLES    = 32'd0,
    parameter int unsigned CTR_W       = 32'd4,
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic lvl_in,
    output logic ready,
    output logic rise,
    output logic fall
);

    // Last count value before each transition fires.
    localparam logic [CTR_W-1:0] A_LAST = CTR_W'(A_CYCLES - 32'd1);
    localparam logic [CTR_W-1:0] D_LAST = (D_CYCLES > 32'd0) ? CTR_W'(D_CYCLES - 32'd1)
                                                             : '0;
    localparam logic [CTR_W-1:0] CNT_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    state_t                 state;
    state_t                 state_nxt;
    logic [CTR_W-1:0]       cnt;
    logic [CTR_W-1:0]       cnt_nxt;
    logic [CTR_W-1:0]       cnt_inc;
    logic                   ready_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    // Metastability synchroniser; deliberately untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lvl_in};
        end
    end

    assign act     = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    // Saturating increment: the count can never wrap back into a false match.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOW;
            cnt   <= '0;
            ready <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Next-state and counter logic; clr overrides every transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOW: begin
                    if (act) begin
                        if (A_CYCLES == 32'd1) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = RISING;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                RISING: begin
                    if (!act) begin
                        // Any inactive sample discards the partial count.
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == A_LAST) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HIGH: begin
                    if (!act) begin
                        if (D_CYCLES <= 32'd1) begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = FALLING;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                FALLING: begin
                    if (act) begin
                        // Recovered inside the release window: ready never dropped.
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == D_LAST) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so ready and its edge pulses land together.
    always_comb begin
        ready_nxt = 1'b0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        ready_nxt = (state_nxt == HIGH) || (state_nxt == FALLING);
        rise_nxt  = ready_nxt & ~ready;
        fall_nxt  = ~ready_nxt & ready;
    end

endmodule : stable_level_chan

// File: rtl/stable_level_detector.sv
// Multi-channel stable level detector.
// Each channel asserts ready only after its synchronised input has been
// continuously active for the assert hold time, and releases it immediately
// or after the deassert filter time. all_ready is the registered AND of ready.
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   clr       : synchronous clear of every channel to LOW
//   lvl_in    : raw asynchronous level inputs, one per channel
//   ready     : per-channel filtered active flags
//   rise      : per-channel one-cycle pulse on ready 0->1
//   fall      : per-channel one-cycle pulse on ready 1->0
//   all_ready : registered AND of all ready bits
module stable_level_detector
    import stable_level_pkg::*;
#(
    parameter int unsigned        NUM_CH      = 32'd4,
    parameter int unsigned        CLK_RATE    = 32'd50000000,
    parameter int unsigned        ASSERT_US   = 32'd20,
    parameter int unsigned        DEASSERT_US = 32'd0,
    parameter int unsigned        SYNC_STAGES = 32'd2,
    parameter logic [NUM_CH-1:0]  ACTIVE_LOW  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [NUM_CH-1:0] lvl_in,
    output logic [NUM_CH-1:0] ready,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              all_ready
);

    localparam int unsigned ASSERT_CYCLES   = us_to_cycles(CLK_RATE, ASSERT_US, 1'b1);
    localparam int unsigned DEASSERT_CYCLES = us_to_cycles(CLK_RATE, DEASSERT_US, 1'b0);
    localparam int unsigned CTR_W           = ctr_width(ASSERT_CYCLES, DEASSERT_CYCLES);

    // Independent channels, no interaction between them.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        stable_level_chan #(
            .A_CYCLES    (ASSERT_CYCLES),
            .D_CYCLES    (DEASSERT_CYCLES),
            .CTR_W       (CTR_W),
            .SYNC_STAGES (SYNC_STAGES),
            .ACTIVE_LOW  (ACTIVE_LOW[i])
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .lvl_in (lvl_in[i]),
            .ready  (ready[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Forced low on clr so it drops on the same edge as the ready bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            all_ready <= 1'b0;
        end else if (clr) begin
            all_ready <= 1'b0;
        end else begin
            all_ready <= &ready;
        end
    end

endmodule : stable_level_detector

// File: tb/tb_stable_level_detector.sv
// Scoreboard bench for stable_level_detector.
// Two instances share clk/rst: dut0 (immediate release, channel 3 active-low)
// and dut1 (4-cycle release filter). Stimulus pushes expected pulse events and
// cycle-stamped level checks; the monitor compares on every pulse and on every
// stamped cycle.
module tb_stable_level_detector;

    localparam int unsigned NCH = 4;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        string       name;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        int          dut;
        logic [3:0]  ready;
        logic        all_ready;
        string       name;
    } lv_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr0;
    logic           clr1;
    logic [NCH-1:0] lvl0;
    logic [NCH-1:0] lvl1;
    logic [NCH-1:0] ready0, rise0, fall0;
    logic [NCH-1:0] ready1, rise1, fall1;
    logic           all0, all1;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          finish_req = 1'b0;
    bit          finish_ack = 1'b0;

    ev_t evq0[$];
    ev_t evq1[$];
    lv_t lvq[$];

    stable_level_detector #(
        .NUM_CH(NCH), .CLK_RATE(1000000), .ASSERT_US(8), .DEASSERT_US(0),
        .SYNC_STAGES(2), .ACTIVE_LOW(4'b1000)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .lvl_in(lvl0),
        .ready(ready0), .rise(rise0), .fall(fall0), .all_ready(all0)
    );

    stable_level_detector #(
        .NUM_CH(NCH), .CLK_RATE(1000000), .ASSERT_US(8), .DEASSERT_US(4),
        .SYNC_STAGES(2), .ACTIVE_LOW(4'b0000)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .lvl_in(lvl1),
        .ready(ready1), .rise(rise1), .fall(fall1), .all_ready(all1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_ev(input int dut, input int unsigned c,
                                   input logic [3:0] r, input logic [3:0] f,
                                   input string n);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.name = n;
        if (dut == 0) evq0.push_back(e);
        else          evq1.push_back(e);
    endfunction

    function automatic void exp_lv(input int dut, input int unsigned c,
                                   input logic [3:0] r, input logic a,
                                   input string n);
        lv_t l;
        l.cyc = c; l.dut = dut; l.ready = r; l.all_ready = a; l.name = n;
        lvq.push_back(l);
    endfunction

    task automatic mon_ev(input int dut, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        bit  empty;
        if ((r | f) != 4'b0000) begin
            tests++;
            empty = (dut == 0) ? (evq0.size() == 0) : (evq1.size() == 0);
            if (empty) begin
                fails++;
                $display("FAIL unexpected_pulse dut%0d cyc=%0d got rise=%b fall=%b, required no pulse",
                         dut, cyc, r, f);
            end else begin
                if (dut == 0) e = evq0.pop_front();
                else          e = evq1.pop_front();
                if ((e.cyc != cyc) || (e.rise !== r) || (e.fall !== f)) begin
                    fails++;
                    $display("FAIL %s dut%0d got cyc=%0d rise=%b fall=%b, required cyc=%0d rise=%b fall=%b",
                             e.name, dut, cyc, r, f, e.cyc, e.rise, e.fall);
                end
            end
        end
    endtask

    task automatic mon_lv();
        logic [3:0] r;
        logic       a;
        for (int i = lvq.size() - 1; i >= 0; i--) begin
            if (lvq[i].cyc == cyc) begin
                r = (lvq[i].dut == 0) ? ready0 : ready1;
                a = (lvq[i].dut == 0) ? all0   : all1;
                tests++;
                if ((r !== lvq[i].ready) || (a !== lvq[i].all_ready)) begin
                    fails++;
                    $display("FAIL %s dut%0d cyc=%0d got ready=%b all_ready=%b, required ready=%b all_ready=%b",
                             lvq[i].name, lvq[i].dut, cyc, r, a, lvq[i].ready, lvq[i].all_ready);
                end
                lvq.delete(i);
            end
        end
    endtask

    task automatic mon_pending(input string n, input int left);
        tests++;
        if (left != 0) begin
            fails++;
            $display("FAIL %s got %0d outstanding expectations, required 0", n, left);
        end
    endtask

    // Monitor: sole owner of the counters.
    always @(negedge clk) begin
        mon_ev(0, rise0, fall0);
        mon_ev(1, rise1, fall1);
        mon_lv();
        if (finish_req && !finish_ack) begin
            mon_pending("pending_events_dut0", evq0.size());
            mon_pending("pending_events_dut1", evq1.size());
            mon_pending("pending_level_checks", lvq.size());
            finish_ack = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        rst  = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        lvl0 = 4'b1000;
        lvl1 = 4'b0000;

        // Reset state.
        repeat (2) @(negedge clk);
        t = cyc;
        exp_lv(0, t + 1, 4'b0000, 1'b0, "reset_state_dut0");
        exp_lv(1, t + 1, 4'b0000, 1'b0, "reset_state_dut1");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Clean rising edge: 2 sync + 8 hold cycles.
        @(negedge clk);
        t = cyc;
        lvl0[0] = 1'b1;
        exp_lv(0, t + 9,  4'b0000, 1'b0, "ch0_not_early");
        exp_ev(0, t + 10, 4'b0001, 4'b0000, "ch0_rise");
        exp_lv(0, t + 10, 4'b0001, 1'b0, "ch0_ready");
        exp_lv(0, t + 11, 4'b0001, 1'b0, "ch0_ready_hold");
        repeat (12) @(negedge clk);

        // Glitch restarts the count from zero.
        lvl0[1] = 1'b1;
        repeat (5) @(negedge clk);
        lvl0[1] = 1'b0;
        @(negedge clk);
        lvl0[1] = 1'b1;
        t = cyc;
        exp_lv(0, t + 9,  4'b0001, 1'b0, "ch1_glitch_no_credit");
        exp_ev(0, t + 10, 4'b0010, 4'b0000, "ch1_rise");
        exp_lv(0, t + 10, 4'b0011, 1'b0, "ch1_ready");
        repeat (12) @(negedge clk);

        // Active-low channel 3 plus channel 2; all_ready lags by one cycle.
        t = cyc;
        lvl0[3] = 1'b0;
        lvl0[2] = 1'b1;
        exp_lv(0, t + 9,  4'b0011, 1'b0, "ch23_not_early");
        exp_ev(0, t + 10, 4'b1100, 4'b0000, "ch23_rise");
        exp_lv(0, t + 10, 4'b1111, 1'b0, "all_ready_lag");
        exp_lv(0, t + 11, 4'b1111, 1'b1, "all_ready_set");
        repeat (12) @(negedge clk);

        // Synchronous clear: fall on every ready channel, then re-qualify.
        t = cyc;
        clr0 = 1'b1;
        exp_ev(0, t + 1,  4'b0000, 4'b1111, "clr_fall");
        exp_lv(0, t + 1,  4'b0000, 1'b0, "clr_ready");
        exp_lv(0, t + 8,  4'b0000, 1'b0, "clr_regain_not_early");
        exp_ev(0, t + 9,  4'b1111, 4'b0000, "clr_regain_rise");
        exp_lv(0, t + 10, 4'b1111, 1'b1, "clr_all_ready");
        @(negedge clk);
        clr0 = 1'b0;
        repeat (12) @(negedge clk);

        // Immediate release: 2 sync + 1.
        t = cyc;
        lvl0[0] = 1'b0;
        exp_lv(0, t + 2, 4'b1111, 1'b1, "drop_not_early");
        exp_ev(0, t + 3, 4'b0000, 4'b0001, "drop_fall");
        exp_lv(0, t + 3, 4'b1110, 1'b1, "all_ready_stale");
        exp_lv(0, t + 4, 4'b1110, 1'b0, "all_ready_clear");
        repeat (6) @(negedge clk);

        // Release filter on dut1.
        t = cyc;
        lvl1[0] = 1'b1;
        exp_ev(1, t + 10, 4'b0001, 4'b0000, "rel_rise");
        repeat (12) @(negedge clk);
        t = cyc;
        lvl1[0] = 1'b0;
        exp_lv(1, t + 5, 4'b0001, 1'b0, "short_low_in_filter");
        exp_lv(1, t + 8, 4'b0001, 1'b0, "short_low_no_fall");
        repeat (3) @(negedge clk);
        lvl1[0] = 1'b1;
        repeat (8) @(negedge clk);
        t = cyc;
        lvl1[0] = 1'b0;
        exp_lv(1, t + 5, 4'b0001, 1'b0, "long_low_3rd_sample");
        exp_ev(1, t + 6, 4'b0000, 4'b0001, "long_low_fall");
        exp_lv(1, t + 6, 4'b0000, 1'b0, "long_low_ready");
        repeat (6) @(negedge clk);
        lvl1[0] = 1'b1;
        exp_ev(1, t + 16, 4'b0001, 4'b0000, "rel_rerise");
        repeat (14) @(negedge clk);

        // Reset in the middle of channel 2's hold count.
        t = cyc;
        lvl0[2] = 1'b0;
        exp_ev(0, t + 3, 4'b0000, 4'b0100, "ch2_drop");
        repeat (5) @(negedge clk);
        lvl0[2] = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        t = cyc;
        exp_lv(0, t, 4'b0000, 1'b0, "rst_async_dut0");
        exp_lv(1, t, 4'b0000, 1'b0, "rst_async_dut1");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        t = cyc;
        // ch3 sees active at once (cleared sync reads 0, active-low); others wait for sync.
        exp_ev(0, t + 8,  4'b1000, 4'b0000, "post_rst_ch3");
        exp_lv(0, t + 9,  4'b1000, 1'b0, "post_rst_no_credit");
        exp_ev(0, t + 10, 4'b0110, 4'b0000, "post_rst_ch12");
        exp_ev(1, t + 10, 4'b0001, 4'b0000, "post_rst_dut1");
        repeat (15) @(negedge clk);

        finish_req = 1'b1;
        wait (finish_ack);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_stable_level_detector

// File: doc/stable_level_detector.md
Name: stable_level_detector

Overview:
Parametrised multi-channel successor to the single-channel cclk-ready detector. Each channel synchronises an asynchronous level input and asserts its ready flag only after the level has been continuously active for a programmable hold time. Ready is deasserted either immediately or after a programmable release filter. The block emits one-cycle rise/fall event pulses and an all-channels-ready flag. It sits at the top level and gates start-up of downstream logic on configuration clock, power-good or link-present style signals.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
CLK_RATE, 50000000, clk frequency in Hz
ASSERT_US, 20, required continuous-active time before ready; ASSERT_CYCLES = max(1, CLK_RATE/1000000*ASSERT_US)
DEASSERT_US, 0, release filter time; DEASSERT_CYCLES = CLK_RATE/1000000*DEASSERT_US; 0 = immediate drop
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
ACTIVE_LOW, 0 (NUM_CH bits), per-channel polarity mask; bit=1 means the input is active when 0

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk upstream
clr  in  1  synchronous clear: all channels return to LOW state
lvl_in  in  NUM_CH  raw asynchronous level inputs
ready  out  NUM_CH  per-channel filtered active flag
rise  out  NUM_CH  one-cycle pulse when ready goes 0->1
fall  out  NUM_CH  one-cycle pulse when ready goes 1->0
all_ready  out  1  registered AND of all ready bits

Behaviour:
- Reset (rst=0): all sync flops, counters, ready, rise, fall and all_ready = 0; every channel in state LOW.
- Per channel, a = sync output XOR ACTIVE_LOW[i]. a is valid SYNC_STAGES cycles after lvl_in changes.
- Counter width CTR_W = clog2(max(ASSERT_CYCLES, DEASSERT_CYCLES)+1). The counter saturates and never wraps.
- FSM per channel:
  - LOW: ready=0. If a=1, set cnt=1 and go to RISING. If ASSERT_CYCLES=1, go directly to HIGH on the same edge.
  - RISING: ready=0. If a=0, set cnt=0 and go to LOW. If a=1 and cnt==ASSERT_CYCLES-1, go to HIGH. Otherwise cnt+1.
  - HIGH: ready=1. If a=0 and DEASSERT_CYCLES=0, go to LOW. If a=0 and DEASSERT_CYCLES>0, set cnt=1 and go to FALLING (or to LOW directly if DEASSERT_CYCLES=1).
  - FALLING: ready=1. If a=1, set cnt=0 and return to HIGH with no pulse. If a=0 and cnt==DEASSERT_CYCLES-1, go to LOW. Otherwise cnt+1.
- Net effect: ready rises on the edge that samples the ASSERT_CYCLES-th consecutive a=1. Latency from a clean lvl_in edge to ready is SYNC_STAGES+ASSERT_CYCLES cycles.
- ready, rise and fall are registered. rise/fall are asserted in the same cycle ready first shows its new value, and last exactly 1 cycle.
- A glitch shorter than ASSERT_CYCLES restarts the count from zero; there is no partial credit.
- all_ready follows the AND of ready with 1 cycle of latency.
- clr=1 has priority over all transitions. On the next edge: state LOW, cnt=0, ready=0, all_ready=0. A fall pulse is issued for every channel whose ready was 1; no rise pulses are issued. Sync flops are not cleared.
- Simultaneous clr and a qualifying rise: clr wins; no rise pulse.
- Reset mid-count: everything returns to 0 asynchronously; no pulses are generated during or on exit from reset.
- Channels are fully independent; there is no cross-channel arbitration.

Decomposition:
- Shared package stable_level_pkg: state enum {LOW, RISING, HIGH, FALLING} (2 bits), function us_to_cycles(clk_rate, us) with min-1 clamp for assert, and function ctr_width(a, d).
- Sub-module stable_level_chan: one channel containing the synchroniser, polarity, FSM, counter, ready/rise/fall. The top instantiates NUM_CH copies via generate and registers all_ready.

Test Plan:
Test parameters: CLK_RATE=1000000, ASSERT_US=8, DEASSERT_US=0, NUM_CH=4, SYNC_STAGES=2.
- Reset then lvl_in[0] 0->1 held -> ready[0]=1 and rise[0]=1 exactly 10 cycles after the edge; rise[0] low on the following cycle.
- lvl_in[1] high for 5 cycles, low 1 cycle, then high held -> ready[1] asserts 10 cycles after the final rising edge, not earlier.
- Channel 0 ready, drop lvl_in[0] -> ready[0]=0 and fall[0]=1 3 cycles after the edge (2 sync + 1).
- Rerun with DEASSERT_US=4: a 3-cycle low pulse on a ready channel leaves ready=1 with no fall; a 6-cycle low gives fall on the 4th sampled low cycle.
- ACTIVE_LOW=4'b1000, lvl_in[3]=0 held -> ready[3]=1 after 10 cycles. All four channels active -> all_ready=1 one cycle after the last ready.
- All channels ready, pulse clr for 1 cycle -> ready=0 and fall=4'b1111 on the next edge, all_ready=0. With inputs still active, ready returns 8 cycles later.
- rst driven low mid-RISING on channel 2 -> all outputs 0 immediately, no pulse; after release, counting restarts from 0.
